// File: rtl/fuzz_stage_pkg.sv
// Shared types and constants for the fuzz input stager.
package fuzz_stage_pkg;

  // Core reset sequencer states.
  typedef enum logic [0:0] {
    S_HOLD = 1'b0,
    S_RUN  = 1'b1
  } seq_state_e;

  localparam int unsigned DEF_BUS_W    = 32;
  localparam int unsigned DEF_NUM_CH   = 8;
  localparam int unsigned DEF_STAGES   = 1;
  localparam int unsigned DEF_RST_HOLD = 4;
  localparam int unsigned DEF_CNT_W    = 16;
  localparam int unsigned STAGES_MAX   = 4;

  // Bits needed to hold the values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/stager_channel_pipe.sv
// One stimulus channel: a STAGES-deep register chain with separate capture and shift enables.
module stager_channel_pipe #(
  parameter int unsigned BUS_W  = 32,
  parameter int unsigned STAGES = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cap_en,
  input  logic             i_shift_en,
  input  logic [BUS_W-1:0] i_data,
  output logic [BUS_W-1:0] o_data
);

  logic [BUS_W-1:0] r_stage [STAGES];

  // Stage 0 loads new stimulus; older stages shift independently so a masked channel
  // keeps replicating its stage 0 value down the pipe.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        r_stage[k] <= '0;
      end
    end else begin
      if (i_cap_en) begin
        r_stage[0] <= i_data;
      end
      if (i_shift_en) begin
        for (int k = 1; k < int'(STAGES); k++) begin
          r_stage[k] <= r_stage[k-1];
        end
      end
    end
  end

  assign o_data = r_stage[STAGES-1];

endmodule

// File: rtl/fuzz_input_stager.sv
// Input-staging shell between the fuzz harness and a core under test: per-channel
// stimulus pipelines, pipeline-fill flag, core reset sequencer and a run-cycle counter.
module fuzz_input_stager
  import fuzz_stage_pkg::*;
#(
  parameter int unsigned BUS_W    = DEF_BUS_W,
  parameter int unsigned NUM_CH   = DEF_NUM_CH,
  parameter int unsigned STAGES   = DEF_STAGES,
  parameter int unsigned RST_HOLD = DEF_RST_HOLD,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NUM_CH*BUS_W-1:0] i_in_data,
  input  logic [NUM_CH-1:0]       i_in_mask,
  input  logic                    i_freeze,
  input  logic                    i_core_resetn_req,
  output logic [NUM_CH*BUS_W-1:0] o_out_data,
  output logic                    o_core_resetn,
  output logic                    o_stage_valid,
  output logic [CNT_W-1:0]        o_cycle_cnt
);

  localparam int unsigned FILL_W = cnt_width(STAGES);
  localparam int unsigned HOLD_W = cnt_width(RST_HOLD);

  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(STAGES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RST_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_GO  = HOLD_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  if (STAGES < 1 || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("fuzz_input_stager: STAGES must be in 1..4");
  end
  if (RST_HOLD < 1) begin : g_bad_hold
    $error("fuzz_input_stager: RST_HOLD must be >= 1");
  end

  logic w_shift_en;
  assign w_shift_en = ~i_freeze;

  // ---------------------------------------------------------------------------
  // Data pipelines
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic w_cap_en;
    assign w_cap_en = i_in_mask[i] & ~i_freeze;

    stager_channel_pipe #(
      .BUS_W  (BUS_W),
      .STAGES (STAGES)
    ) u_pipe (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_cap_en   (w_cap_en),
      .i_shift_en (w_shift_en),
      .i_data     (i_in_data[i*BUS_W +: BUS_W]),
      .o_data     (o_out_data[i*BUS_W +: BUS_W])
    );
  end

  // ---------------------------------------------------------------------------
  // Pipeline fill tracking
  // ---------------------------------------------------------------------------
  logic [FILL_W-1:0] r_fill_cnt;

  // Count unfrozen cycles since reset, saturating once every stage holds real data.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_fill_cnt <= '0;
    end else if (w_shift_en && (r_fill_cnt != FILL_MAX)) begin
      r_fill_cnt <= r_fill_cnt + 1'b1;
    end
  end

  assign o_stage_valid = (r_fill_cnt == FILL_MAX);

  // ---------------------------------------------------------------------------
  // Core reset sequencer
  // ---------------------------------------------------------------------------
  seq_state_e        r_state;
  seq_state_e        w_state_d;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_cnt_d;
  logic              r_core_resetn;
  logic              w_core_resetn_d;

  // Next-state logic: hold the core in reset for at least RST_HOLD cycles and for as
  // long as the harness keeps requesting it.
  always_comb begin
    w_state_d    = r_state;
    w_hold_cnt_d = r_hold_cnt;
    unique case (r_state)
      S_HOLD: begin
        if (r_hold_cnt != HOLD_MAX) begin
          w_hold_cnt_d = r_hold_cnt + 1'b1;
        end
        if ((r_hold_cnt >= HOLD_GO) && i_core_resetn_req) begin
          w_state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!i_core_resetn_req) begin
          w_state_d    = S_HOLD;
          w_hold_cnt_d = '0;
        end
      end
      default: begin
        w_state_d    = S_HOLD;
        w_hold_cnt_d = '0;
      end
    endcase
  end

  assign w_core_resetn_d = (w_state_d == S_RUN);

  // Sequencer state and registered core reset output.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_HOLD;
      r_hold_cnt    <= '0;
      r_core_resetn <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_hold_cnt    <= w_hold_cnt_d;
      r_core_resetn <= w_core_resetn_d;
    end
  end

  assign o_core_resetn = r_core_resetn;

  // ---------------------------------------------------------------------------
  // Cycles-since-release counter
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] w_cycle_cnt_d;

  // Reads 0 whenever core_resetn is low; counts completed run cycles otherwise.
  always_comb begin
    w_cycle_cnt_d = '0;
    if (w_core_resetn_d && r_core_resetn) begin
      w_cycle_cnt_d = (r_cycle_cnt == CNT_MAX) ? r_cycle_cnt : r_cycle_cnt + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cycle_cnt <= '0;
    end else begin
      r_cycle_cnt <= w_cycle_cnt_d;
    end
  end

  assign o_cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_fuzz_input_stager.sv
// Self-checking bench for fuzz_input_stager: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a queue-based reference model.
module tb_fuzz_input_stager;

  localparam int unsigned BUS_W    = 32;
  localparam int unsigned NUM_CH   = 8;
  localparam int unsigned STAGES   = 2;
  localparam int unsigned RST_HOLD = 4;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned FW       = NUM_CH * BUS_W;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst;
  logic [FW-1:0]     in_data;
  logic [NUM_CH-1:0] in_mask;
  logic              freeze;
  logic              req;
  logic [FW-1:0]     out_data;
  logic              core_resetn;
  logic              stage_valid;
  logic [CNT_W-1:0]  cycle_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  fuzz_input_stager #(
    .BUS_W    (BUS_W),
    .NUM_CH   (NUM_CH),
    .STAGES   (STAGES),
    .RST_HOLD (RST_HOLD),
    .CNT_W    (CNT_W)
  ) dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_in_data         (in_data),
    .i_in_mask         (in_mask),
    .i_freeze          (freeze),
    .i_core_resetn_req (req),
    .o_out_data        (out_data),
    .o_core_resetn     (core_resetn),
    .o_stage_valid     (stage_valid),
    .o_cycle_cnt       (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // m_q holds the flat stage-0 contents after each unfrozen edge; the oldest entry
  // is what must be on out_data. Reset state is STAGES all-zero entries.
  // ---------------------------------------------------------------------------
  logic [FW-1:0] m_q[$];
  int            m_fill;      // unfrozen edges since reset
  bit            m_run;       // expected core_resetn
  int            m_hold_age;  // edges spent in the current reset episode
  int            m_run_age;   // edges core_resetn has stayed high

  task automatic m_reset();
    m_q.delete();
    for (int s = 0; s < int'(STAGES); s++) m_q.push_back('0);
    m_fill     = 0;
    m_run      = 1'b0;
    m_hold_age = 0;
    m_run_age  = 0;
  endtask

  task automatic m_step();
    logic [FW-1:0] s0;
    bit            was_run;
    if (!freeze) begin
      s0 = m_q[m_q.size()-1];
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (in_mask[c]) s0[c*BUS_W +: BUS_W] = in_data[c*BUS_W +: BUS_W];
      end
      m_q.push_back(s0);
      void'(m_q.pop_front());
      if (m_fill < int'(STAGES)) m_fill++;
    end
    was_run = m_run;
    if (m_run) begin
      if (!req) begin
        m_run      = 1'b0;
        m_hold_age = 0;
      end
    end else begin
      if (m_hold_age >= int'(RST_HOLD) - 1 && req) m_run = 1'b1;
      m_hold_age++;
    end
    if (m_run && was_run) m_run_age++;
    else m_run_age = 0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else m_step();
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [BUS_W-1:0] ch_of(input logic [FW-1:0] v, input int c);
    return v[c*BUS_W +: BUS_W];
  endfunction

  // Compare all outputs against the model on every falling edge.
  initial begin
    int e_cnt;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        e_cnt = (m_run_age > CNT_MAX) ? CNT_MAX : m_run_age;
        check("model_out_data", out_data, m_q[0]);
        check("model_core_resetn", core_resetn, m_run);
        check("model_stage_valid", stage_valid, m_fill >= int'(STAGES));
        check("model_cycle_cnt", cycle_cnt, e_cnt[CNT_W-1:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic run_random(input int cycles);
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      for (int c = 0; c < int'(NUM_CH); c++) in_data[c*BUS_W +: BUS_W] = $urandom;
      in_mask = NUM_CH'($urandom);
      freeze  = ($urandom_range(3) == 0);
      req     = ($urandom_range(19) != 0);
    end
  endtask

  initial begin
    int rise_at;
    int low_cnt;

    rst     = 1'b1;
    in_data = '0;
    in_mask = '1;
    freeze  = 1'b0;
    req     = 1'b1;

    @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_out_data", out_data, '0);
    check("rst_core_resetn", core_resetn, 1'b0);
    check("rst_stage_valid", stage_valid, 1'b0);
    check("rst_cycle_cnt", cycle_cnt, '0);
    rst = 1'b0;

    // Release timing of core_resetn and pipeline fill flag.
    rise_at = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) check("valid_cycle1", stage_valid, 1'b0);
      if (i == 2) check("valid_cycle2", stage_valid, 1'b1);
      if (core_resetn) begin
        rise_at = i;
        break;
      end
    end
    check("release_latency", rise_at, 4);

    // Two-cycle latency of a single word.
    in_data[0 +: BUS_W] = 32'hDEADBEEF;
    @(negedge clk);
    check("lat_ch0_t1", ch_of(out_data, 0), 32'h0);
    in_data[0 +: BUS_W] = 32'h1234;
    @(negedge clk);
    check("lat_ch0_t2", ch_of(out_data, 0), 32'hDEADBEEF);

    // Freeze with 0x1 at the output and 0x2 behind it.
    in_data[0 +: BUS_W] = 32'h1;
    @(negedge clk);
    in_data[0 +: BUS_W] = 32'h2;
    @(negedge clk);
    check("frz_before", ch_of(out_data, 0), 32'h1);
    freeze = 1'b1;
    in_data[0 +: BUS_W] = 32'h3;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("frz_hold", ch_of(out_data, 0), 32'h1);
    end
    freeze = 1'b0;
    in_data[0 +: BUS_W] = 32'h4;
    @(negedge clk);
    check("frz_after1", ch_of(out_data, 0), 32'h2);
    @(negedge clk);
    check("frz_after2", ch_of(out_data, 0), 32'h4);

    // Masking channel 3.
    for (int c = 0; c < int'(NUM_CH); c++) in_data[c*BUS_W +: BUS_W] = 32'hAAAA0000 | c;
    @(negedge clk);
    @(negedge clk);
    check("mask_pre_ch3", ch_of(out_data, 3), 32'hAAAA0003);
    for (int c = 0; c < int'(NUM_CH); c++) in_data[c*BUS_W +: BUS_W] = 32'hBBBB0000 | c;
    in_data[3*BUS_W +: BUS_W] = 32'h55;
    in_mask = 8'hF7;
    @(negedge clk);
    @(negedge clk);
    check("mask_ch3_kept", ch_of(out_data, 3), 32'hAAAA0003);
    check("mask_ch5_new", ch_of(out_data, 5), 32'hBBBB0005);
    in_mask = '1;

    // One-cycle request pulse: core_resetn low for exactly RST_HOLD cycles.
    req = 1'b0;
    @(negedge clk);
    check("pulse_low", core_resetn, 1'b0);
    req = 1'b1;
    low_cnt = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (core_resetn) break;
      low_cnt++;
      check("pulse_cnt_clear", cycle_cnt, '0);
    end
    check("pulse_low_len", low_cnt, 4);
    check("pulse_cnt_at_rise", cycle_cnt, '0);
    @(negedge clk);
    check("pulse_cnt_restart", cycle_cnt, 4'd1);

    // Saturation of a 4-bit counter.
    repeat (20) @(negedge clk);
    check("cnt_saturate", cycle_cnt, 4'd15);
    @(negedge clk);
    check("cnt_no_wrap", cycle_cnt, 4'd15);

    run_random(300);

    // Asynchronous reset mid-run with data in flight.
    @(negedge clk);
    freeze = 1'b0;
    in_mask = '1;
    req = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("async_out_data", out_data, '0);
    check("async_core_resetn", core_resetn, 1'b0);
    check("async_stage_valid", stage_valid, 1'b0);
    check("async_cycle_cnt", cycle_cnt, '0);
    @(negedge clk);
    rst = 1'b0;

    run_random(200);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
